// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-return owner
// codes and the data-memory window compare.
package dmem_arbiter_pkg;

    localparam logic [31:0] DMEM_BASE_DEF = 32'h0010_0000;
    localparam int          MAX_WAIT_DEF  = 4;

    typedef enum logic {
        ST_OPEN  = 1'b0,
        ST_HLOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_H = 1'b1
    } arb_owner_e;

    // Word address bits [29:18] are byte address bits [31:20].
    function automatic logic in_window(input logic [29:0] waddr, input logic [31:0] base);
        return waddr[29:18] == base[31:20];
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the host was denied the memory port.
module arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign at_max = (cnt_q == 4'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (core C, host H) onto the single data-memory port, with
// same-cycle grant, host starvation guard, host lock and tagged read return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
    parameter int          MAX_WAIT  = MAX_WAIT_DEF
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        C_REQ,
    input  logic [29:0] C_ADDR,
    input  logic [3:0]  C_WSTB,
    input  logic [31:0] C_WDATA,
    output logic        C_GNT,
    output logic        C_RVALID,
    output logic [31:0] C_RDATA,
    output logic        C_ERR,
    input  logic        H_REQ,
    input  logic        H_LOCK,
    input  logic [29:0] H_ADDR,
    input  logic [3:0]  H_WSTB,
    input  logic [31:0] H_WDATA,
    output logic        H_GNT,
    output logic        H_RVALID,
    output logic [31:0] H_RDATA,
    output logic        H_ERR,
    output logic        M_CE,
    output logic [29:0] M_ADDR,
    output logic [3:0]  M_WSTB,
    output logic [31:0] M_DATAO,
    input  logic [31:0] M_DATAI
);

    arb_state_e state_q, state_d;
    arb_owner_e rd_own_q, rd_own_d;
    logic       rd_vld_q, rd_vld_d;
    logic       rd_err_q, rd_err_d;

    logic       c_gnt, h_gnt, any_gnt;
    logic       at_max, h_inc, h_clr;
    logic       in_win;
    logic [31:0] rd_data;

    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (state_q == ST_HLOCK) begin
            h_gnt = H_REQ;
        end else begin
            h_gnt = H_REQ && (!C_REQ || at_max);
            c_gnt = C_REQ && !h_gnt;
        end
        // Grants must not escape while reset is asserted, even between edges.
        if (!RSTN) begin
            c_gnt = 1'b0;
            h_gnt = 1'b0;
        end
    end

    assign any_gnt = c_gnt || h_gnt;
    assign C_GNT   = c_gnt;
    assign H_GNT   = h_gnt;

    assign h_inc = H_REQ && !h_gnt && (state_q == ST_OPEN);
    assign h_clr = h_gnt || !H_REQ;

    arb_starve_cnt #(
        .MAX (MAX_WAIT)
    ) u_starve_cnt (
        .clk    (CLK),
        .rst_n  (RSTN),
        .inc    (h_inc),
        .clr    (h_clr),
        .at_max (at_max)
    );

    always_comb begin
        M_ADDR  = 30'd0;
        M_WSTB  = 4'd0;
        M_DATAO = 32'd0;
        if (h_gnt) begin
            M_ADDR  = H_ADDR;
            M_WSTB  = H_WSTB;
            M_DATAO = H_WDATA;
        end else if (c_gnt) begin
            M_ADDR  = C_ADDR;
            M_WSTB  = C_WSTB;
            M_DATAO = C_WDATA;
        end
    end

    // Out-of-window beats are granted but never reach the memory.
    assign in_win = in_window(M_ADDR, DMEM_BASE);
    assign M_CE   = any_gnt && in_win;

    always_comb begin
        state_d  = state_q;
        if (h_gnt) begin
            state_d = H_LOCK ? ST_HLOCK : ST_OPEN;
        end
        rd_vld_d = any_gnt && (M_WSTB == 4'd0);
        rd_own_d = h_gnt ? OWN_H : OWN_C;
        rd_err_d = !in_win;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_OPEN;
            rd_vld_q <= 1'b0;
            rd_own_q <= OWN_C;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_vld_d;
            rd_own_q <= rd_own_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign rd_data  = (rd_vld_q && !rd_err_q) ? M_DATAI : 32'd0;

    assign C_RVALID = rd_vld_q && (rd_own_q == OWN_C);
    assign H_RVALID = rd_vld_q && (rd_own_q == OWN_H);
    assign C_ERR    = C_RVALID && rd_err_q;
    assign H_ERR    = H_RVALID && rd_err_q;
    assign C_RDATA  = C_RVALID ? rd_data : 32'd0;
    assign H_RDATA  = H_RVALID ? rd_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-strobed registered-read memory model.
module tb_dmem_arbiter;

    logic        CLK;
    logic        RSTN;
    logic        C_REQ;
    logic [29:0] C_ADDR;
    logic [3:0]  C_WSTB;
    logic [31:0] C_WDATA;
    logic        C_GNT;
    logic        C_RVALID;
    logic [31:0] C_RDATA;
    logic        C_ERR;
    logic        H_REQ;
    logic        H_LOCK;
    logic [29:0] H_ADDR;
    logic [3:0]  H_WSTB;
    logic [31:0] H_WDATA;
    logic        H_GNT;
    logic        H_RVALID;
    logic [31:0] H_RDATA;
    logic        H_ERR;
    logic        M_CE;
    logic [29:0] M_ADDR;
    logic [3:0]  M_WSTB;
    logic [31:0] M_DATAO;
    logic [31:0] M_DATAI;

    logic [31:0] mem [0:1023];
    logic [31:0] burst [0:3];

    int n_tests;
    int n_fail;

    dmem_arbiter #(
        .DMEM_BASE (32'h0010_0000),
        .MAX_WAIT  (4)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .C_REQ    (C_REQ),
        .C_ADDR   (C_ADDR),
        .C_WSTB   (C_WSTB),
        .C_WDATA  (C_WDATA),
        .C_GNT    (C_GNT),
        .C_RVALID (C_RVALID),
        .C_RDATA  (C_RDATA),
        .C_ERR    (C_ERR),
        .H_REQ    (H_REQ),
        .H_LOCK   (H_LOCK),
        .H_ADDR   (H_ADDR),
        .H_WSTB   (H_WSTB),
        .H_WDATA  (H_WDATA),
        .H_GNT    (H_GNT),
        .H_RVALID (H_RVALID),
        .H_RDATA  (H_RDATA),
        .H_ERR    (H_ERR),
        .M_CE     (M_CE),
        .M_ADDR   (M_ADDR),
        .M_WSTB   (M_WSTB),
        .M_DATAO  (M_DATAO),
        .M_DATAI  (M_DATAI)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model: read-before-write, data valid one cycle after M_CE.
    always @(posedge CLK) begin
        if (M_CE) begin
            for (int b = 0; b < 4; b++) begin
                if (M_WSTB[b]) mem[M_ADDR[9:0]][8*b +: 8] <= M_DATAO[8*b +: 8];
            end
            M_DATAI <= mem[M_ADDR[9:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_c(input logic req, input logic [29:0] addr, input logic [3:0] wstb,
                           input logic [31:0] wdata);
        C_REQ   = req;
        C_ADDR  = addr;
        C_WSTB  = wstb;
        C_WDATA = wdata;
    endtask

    task automatic drive_h(input logic req, input logic lock, input logic [29:0] addr,
                           input logic [3:0] wstb, input logic [31:0] wdata);
        H_REQ   = req;
        H_LOCK  = lock;
        H_ADDR  = addr;
        H_WSTB  = wstb;
        H_WDATA = wdata;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        burst[0] = 32'h1111_0000;
        burst[1] = 32'h2222_0001;
        burst[2] = 32'h3333_0002;
        burst[3] = 32'h4444_0003;

        // Reset with both requesters active: nothing may be granted.
        RSTN = 1'b0;
        drive_c(1'b1, 30'h0004_0001, 4'h0, 32'd0);
        drive_h(1'b1, 1'b0, 30'h0004_0000, 4'h0, 32'd0);
        #3;
        check_eq("rst_c_gnt", 32'(C_GNT), 32'd0);
        check_eq("rst_h_gnt", 32'(H_GNT), 32'd0);
        check_eq("rst_m_ce", 32'(M_CE), 32'd0);
        check_eq("rst_m_addr", 32'(M_ADDR), 32'd0);
        check_eq("rst_c_rvalid", 32'(C_RVALID), 32'd0);
        check_eq("rst_h_rvalid", 32'(H_RVALID), 32'd0);
        cyc;
        drive_c(1'b0, 30'd0, 4'h0, 32'd0);
        drive_h(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        RSTN = 1'b1;
        cyc;

        // C-only write then read back
        drive_c(1'b1, 30'h0004_0001, 4'hF, 32'hDEAD_BEEF);
        #1;
        check_eq("c_wr_gnt", 32'(C_GNT), 32'd1);
        check_eq("c_wr_ce", 32'(M_CE), 32'd1);
        cyc;
        check_eq("c_wr_no_rvalid", 32'(C_RVALID), 32'd0);
        drive_c(1'b1, 30'h0004_0001, 4'h0, 32'd0);
        #1;
        check_eq("c_rd_gnt", 32'(C_GNT), 32'd1);
        check_eq("c_rd_ce", 32'(M_CE), 32'd1);
        check_eq("c_rd_m_addr", 32'(M_ADDR), 32'h0004_0001);
        cyc;
        drive_c(1'b0, 30'd0, 4'h0, 32'd0);
        #1;
        check_eq("c_rd_rvalid", 32'(C_RVALID), 32'd1);
        check_eq("c_rd_rdata", C_RDATA, 32'hDEAD_BEEF);
        check_eq("c_rd_h_rvalid", 32'(H_RVALID), 32'd0);
        check_eq("c_rd_h_rdata", H_RDATA, 32'd0);
        cyc;

        // Contention: C wins four cycles, H the fifth, C again the sixth
        drive_c(1'b1, 30'h0004_0001, 4'h0, 32'd0);
        drive_h(1'b1, 1'b0, 30'h0004_0000, 4'h0, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            #1;
            check_eq($sformatf("starve_c_gnt_%0d", k), 32'(C_GNT), (k == 5) ? 32'd0 : 32'd1);
            check_eq($sformatf("starve_h_gnt_%0d", k), 32'(H_GNT), (k == 5) ? 32'd1 : 32'd0);
            if (k == 6) begin
                check_eq("starve_h_rvalid", 32'(H_RVALID), 32'd1);
                check_eq("starve_c_rvalid", 32'(C_RVALID), 32'd0);
            end
            cyc;
        end
        drive_c(1'b0, 30'd0, 4'h0, 32'd0);
        drive_h(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        cyc;

        // Host lock burst with an idle locked cycle in the middle
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                drive_h(1'b0, 1'b1, 30'd0, 4'h0, 32'd0);
                drive_c(1'b1, 30'h0004_0001, 4'h0, 32'd0);
                #1;
                check_eq("lock_idle_c_gnt", 32'(C_GNT), 32'd0);
                check_eq("lock_idle_h_gnt", 32'(H_GNT), 32'd0);
                cyc;
            end
            drive_h(1'b1, (i != 3), 30'h0004_0000 + 30'(i), 4'hF, burst[i]);
            drive_c((i > 0), 30'h0004_0001, 4'h0, 32'd0);
            #1;
            check_eq($sformatf("lock_h_gnt_%0d", i), 32'(H_GNT), 32'd1);
            check_eq($sformatf("lock_c_gnt_%0d", i), 32'(C_GNT), 32'd0);
            cyc;
        end
        drive_h(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        drive_c(1'b1, 30'h0004_0001, 4'h0, 32'd0);
        #1;
        check_eq("unlock_c_gnt", 32'(C_GNT), 32'd1);
        cyc;
        drive_c(1'b0, 30'd0, 4'h0, 32'd0);
        #1;
        check_eq("unlock_c_rvalid", 32'(C_RVALID), 32'd1);
        check_eq("unlock_c_rdata", C_RDATA, burst[1]);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("burst_mem_%0d", i), mem[i], burst[i]);
        end
        cyc;

        // Out-of-window read then write (byte address 0x00200000)
        drive_c(1'b1, 30'h0008_0000, 4'h0, 32'd0);
        #1;
        check_eq("oow_rd_gnt", 32'(C_GNT), 32'd1);
        check_eq("oow_rd_ce", 32'(M_CE), 32'd0);
        cyc;
        drive_c(1'b1, 30'h0008_0000, 4'hF, 32'hBAD0_BAD0);
        #1;
        check_eq("oow_rd_rvalid", 32'(C_RVALID), 32'd1);
        check_eq("oow_rd_err", 32'(C_ERR), 32'd1);
        check_eq("oow_rd_rdata", C_RDATA, 32'd0);
        check_eq("oow_wr_gnt", 32'(C_GNT), 32'd1);
        check_eq("oow_wr_ce", 32'(M_CE), 32'd0);
        cyc;
        drive_c(1'b0, 30'd0, 4'h0, 32'd0);
        #1;
        check_eq("oow_wr_no_rvalid", 32'(C_RVALID), 32'd0);
        check_eq("oow_wr_mem_intact", mem[0], burst[0]);
        cyc;

        // Interleaved returns: H read then C read on consecutive cycles
        drive_h(1'b1, 1'b0, 30'h0004_0002, 4'h0, 32'd0);
        #1;
        check_eq("ilv_h_gnt", 32'(H_GNT), 32'd1);
        cyc;
        drive_h(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        drive_c(1'b1, 30'h0004_0003, 4'h0, 32'd0);
        #1;
        check_eq("ilv_c_gnt", 32'(C_GNT), 32'd1);
        check_eq("ilv_h_rvalid", 32'(H_RVALID), 32'd1);
        check_eq("ilv_h_rdata", H_RDATA, burst[2]);
        check_eq("ilv_c_rvalid_early", 32'(C_RVALID), 32'd0);
        check_eq("ilv_c_rdata_early", C_RDATA, 32'd0);
        cyc;
        drive_c(1'b0, 30'd0, 4'h0, 32'd0);
        #1;
        check_eq("ilv_c_rvalid", 32'(C_RVALID), 32'd1);
        check_eq("ilv_c_rdata", C_RDATA, burst[3]);
        check_eq("ilv_h_rvalid_late", 32'(H_RVALID), 32'd0);
        check_eq("ilv_h_rdata_late", H_RDATA, 32'd0);
        cyc;

        // Async reset while locked with a read pending
        drive_h(1'b1, 1'b1, 30'h0004_0000, 4'h0, 32'd0);
        #1;
        check_eq("arst_h_gnt", 32'(H_GNT), 32'd1);
        cyc;
        drive_c(1'b1, 30'h0004_0001, 4'h0, 32'd0);
        #1;
        check_eq("arst_pre_h_rvalid", 32'(H_RVALID), 32'd1);
        check_eq("arst_pre_c_gnt", 32'(C_GNT), 32'd0);
        #1;
        RSTN = 1'b0;
        #1;
        check_eq("arst_h_gnt_drop", 32'(H_GNT), 32'd0);
        check_eq("arst_h_rvalid_drop", 32'(H_RVALID), 32'd0);
        check_eq("arst_c_gnt_low", 32'(C_GNT), 32'd0);
        check_eq("arst_m_ce_low", 32'(M_CE), 32'd0);
        drive_h(1'b0, 1'b0, 30'd0, 4'h0, 32'd0);
        cyc;
        RSTN = 1'b1;
        #1;
        check_eq("post_rst_c_gnt", 32'(C_GNT), 32'd1);
        check_eq("post_rst_c_rvalid", 32'(C_RVALID), 32'd0);
        cyc;
        drive_c(1'b0, 30'd0, 4'h0, 32'd0);
        #1;
        check_eq("post_rst_c_rdata", C_RDATA, burst[1]);
        cyc;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
